// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: sequencing controller for the uart_rx receiver.
//   Generates the three-per-bit sampling strobes, captures each new byte into
//   a small FIFO behind a valid/ready stream, and recovers the receiver from
//   its sticky error state with a one-cycle reset pulse.
// Optional feature macro: UART_RX_CTRL_ERRCNT_EN (error counter; tied to 0 when undefined).
// Ports:
//   i_clk, i_rst_n          clock, async active-low reset
//   i_rx_data/i_rx_valid    receiver byte and level-held valid
//   o_rx_ready              constant 1 to receiver
//   i_rx_sync, i_rx_err     receiver start-bit detect, sticky error
//   o_rx_pulse, o_rx_rst    sampling strobe and active-high reset to receiver
//   o_data/o_valid/i_ready  consumer stream (FIFO head)
//   o_err_cnt, o_ovf, o_busy  status
module uart_rx_ctrl #(
  parameter int unsigned CLKS_PER_BIT = 48,
  parameter int unsigned FIFO_AW      = 2
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_rx_data,
  input  logic       i_rx_valid,
  output logic       o_rx_ready,
  input  logic       i_rx_sync,
  input  logic       i_rx_err,
  output logic       o_rx_pulse,
  output logic       o_rx_rst,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_ready,
  output logic [7:0] o_err_cnt,
  output logic       o_ovf,
  output logic       o_busy
);

  localparam int unsigned CW    = $clog2(CLKS_PER_BIT);
  localparam int unsigned BW    = 4;
  localparam int unsigned H     = CLKS_PER_BIT / 2;
  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam int unsigned CNTW  = FIFO_AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_FRAME, S_RECOVER} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      c_q, c_d;
  logic [BW-1:0]      b_q, b_d;
  logic               err_q, valid_q;
  logic               err_rise, pulse_d;
  logic               push, pop, full, wr_en;
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0]    cnt_q, cnt_d;
  logic [7:0]         head_d;
  logic [7:0]         mem_q [DEPTH];

  assign o_rx_ready = 1'b1;

  // Frame sequencing: error rise overrides everything, sync restarts the frame.
  always_comb begin
    state_d  = state_q;
    c_d      = c_q;
    b_d      = b_q;
    err_rise = i_rx_err & ~err_q;
    if (err_rise) begin
      state_d = S_RECOVER;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_rx_sync) begin
            state_d = S_FRAME;
            c_d     = '0;
            b_d     = '0;
          end
        end
        S_FRAME: begin
          if (i_rx_sync) begin
            c_d = '0;
            b_d = '0;
          end else if (c_q == CW'(CLKS_PER_BIT - 1)) begin
            c_d = '0;
            if (b_q == BW'(9)) state_d = S_IDLE;
            else               b_d = b_q + BW'(1);
          end else begin
            c_d = c_q + CW'(1);
          end
        end
        S_RECOVER: state_d = S_IDLE;
        default:   state_d = S_IDLE;
      endcase
    end
    // Strobe is registered from next-state so it lines up with c in the same cycle.
    pulse_d = (state_d == S_FRAME) &&
              ((c_d == CW'(H - 1)) || (c_d == CW'(H)) || (c_d == CW'(H + 1)));
  end

  // FIFO control; a byte written into the slot becoming head is forwarded.
  always_comb begin
    pop      = o_valid & i_ready;
    push     = i_rx_valid & ~valid_q & (state_q != S_RECOVER);
    full     = (cnt_q == CNTW'(DEPTH));
    wr_en    = push & (~full | pop);
    rd_ptr_d = pop ? rd_ptr_q + FIFO_AW'(1) : rd_ptr_q;
    cnt_d    = cnt_q;
    if (wr_en && !pop)      cnt_d = cnt_q + CNTW'(1);
    else if (!wr_en && pop) cnt_d = cnt_q - CNTW'(1);
    head_d = (wr_en && (wr_ptr_q == rd_ptr_d)) ? i_rx_data : mem_q[rd_ptr_d];
  end

  // Storage array, no reset needed: occupancy is tracked by cnt_q.
  always_ff @(posedge i_clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= i_rx_data;
  end

  // State, counters and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      c_q        <= '0;
      b_q        <= '0;
      err_q      <= 1'b0;
      valid_q    <= 1'b1;
      o_rx_pulse <= 1'b0;
      o_rx_rst   <= 1'b1;
      o_busy     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      o_valid    <= 1'b0;
      o_data     <= 8'h00;
      o_ovf      <= 1'b0;
    end else begin
      state_q    <= state_d;
      c_q        <= c_d;
      b_q        <= b_d;
      err_q      <= i_rx_err;
      // The receiver comes out of reset with valid=1/data=0; mask that edge.
      valid_q    <= (state_q == S_RECOVER) ? 1'b1 : i_rx_valid;
      o_rx_pulse <= pulse_d;
      o_rx_rst   <= (state_d == S_RECOVER);
      o_busy     <= (state_d == S_FRAME);
      if (wr_en) wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      o_valid    <= (cnt_d != '0);
      if (cnt_d != '0) o_data <= head_d;
      if (push && full && !pop) o_ovf <= 1'b1;
    end
  end

`ifdef UART_RX_CTRL_ERRCNT_EN
  // Saturating count of recovery events.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_err_cnt <= 8'h00;
    end else if ((state_q == S_RECOVER) && (o_err_cnt != 8'hFF)) begin
      o_err_cnt <= o_err_cnt + 8'd1;
    end
  end
`else
  assign o_err_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl with a byte scoreboard queue.
module tb_uart_rx_ctrl;
  localparam int CPB = 16;
  localparam int AW  = 2;
  localparam int H   = CPB / 2;

  logic       i_clk = 1'b0;
  logic       i_rst_n;
  logic [7:0] i_rx_data;
  logic       i_rx_valid;
  logic       o_rx_ready;
  logic       i_rx_sync;
  logic       i_rx_err;
  logic       o_rx_pulse;
  logic       o_rx_rst;
  logic [7:0] o_data;
  logic       o_valid;
  logic       i_ready;
  logic [7:0] o_err_cnt;
  logic       o_ovf;
  logic       o_busy;

  always #5 i_clk = ~i_clk;

  uart_rx_ctrl #(.CLKS_PER_BIT(CPB), .FIFO_AW(AW)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid),
    .o_rx_ready(o_rx_ready), .i_rx_sync(i_rx_sync), .i_rx_err(i_rx_err),
    .o_rx_pulse(o_rx_pulse), .o_rx_rst(o_rx_rst), .o_data(o_data), .o_valid(o_valid),
    .i_ready(i_ready), .o_err_cnt(o_err_cnt), .o_ovf(o_ovf), .o_busy(o_busy)
  );

  int         tests = 0;
  int         failed = 0;
  int         rst_pulses = 0;
  int         err_events = 0;
  logic [7:0] sb[$];

  task automatic check1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checki(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_err_cnt();
`ifdef UART_RX_CTRL_ERRCNT_EN
    return (err_events > 255) ? 255 : err_events;
`else
    return 0;
`endif
  endfunction

  task automatic check_reset_outputs(input string tag);
    check1({tag, "_rx_rst"}, o_rx_rst, 1'b1);
    check1({tag, "_pulse"}, o_rx_pulse, 1'b0);
    check1({tag, "_valid"}, o_valid, 1'b0);
    check8({tag, "_data"}, o_data, 8'h00);
    check8({tag, "_err_cnt"}, o_err_cnt, 8'h00);
    check1({tag, "_ovf"}, o_ovf, 1'b0);
    check1({tag, "_busy"}, o_busy, 1'b0);
    check1({tag, "_ready"}, o_rx_ready, 1'b1);
  endtask

  // One line frame: sync, 10 bits, byte (or error) raised mid stop bit.
  task automatic frame(input logic [7:0] d, input bit keep, input bit err, input bit pop_at_push);
    int   pulses = 0;
    int   bad = 0;
    int   rc = 0;
    int   kend = err ? 151 : 160;
    logic exp_p;
    @(negedge i_clk);
    i_rx_sync  = 1'b1;
    i_rx_valid = 1'b0;
    @(negedge i_clk);
    i_rx_sync  = 1'b0;
    for (int k = 0; k <= 162; k++) begin
      exp_p = ((k % CPB) >= H - 1) && ((k % CPB) <= H + 1) && (k < kend);
      if (o_rx_pulse === 1'b1) pulses++;
      if (o_rx_pulse !== exp_p) bad++;
      if (o_rx_rst === 1'b1) rc++;
      if (k == 5) check1("busy_mid", o_busy, 1'b1);
      if (k == 150) begin
        check1("valid_before_push", o_valid, sb.size() != 0);
        if (err) begin
          i_rx_err = 1'b1;
        end else begin
          if (pop_at_push) begin
            check8("head_at_pop", o_data, sb[0]);
            void'(sb.pop_front());
            i_ready = 1'b1;
          end
          i_rx_valid = 1'b1;
          i_rx_data  = d;
          if (keep) sb.push_back(d);
        end
      end
      if (k == 151) begin
        i_ready = 1'b0;
        if (err) begin
          check1("rst_high", o_rx_rst, 1'b1);
        end else begin
          check1("valid_after_push", o_valid, 1'b1);
          check8("head_after_push", o_data, sb[0]);
        end
      end
      if (k == 152 && err) check1("rst_low", o_rx_rst, 1'b0);
      // Receiver model: reset clears the error and leaves valid=1, data=0.
      if (err && o_rx_rst === 1'b1) begin
        i_rx_err   = 1'b0;
        i_rx_valid = 1'b1;
        i_rx_data  = 8'h00;
      end
      @(negedge i_clk);
    end
    checki("pulse_count", pulses, err ? 27 : 30);
    checki("pulse_position", bad, 0);
    check1("busy_end", o_busy, 1'b0);
    check1("valid_end", o_valid, sb.size() != 0);
    if (err) begin
      err_events++;
      checki("rst_cycles", rc, 1);
    end
    rst_pulses += rc;
  endtask

  // Pop until empty, comparing each head byte against the scoreboard.
  task automatic drain(input string tag);
    logic [7:0] e;
    for (int i = 0; i < 8 && o_valid === 1'b1; i++) begin
      if (sb.size() == 0) begin
        check1({tag, "_extra_byte"}, o_valid, 1'b0);
        break;
      end
      e = sb.pop_front();
      check8({tag, "_pop"}, o_data, e);
      i_ready = 1'b1;
      @(negedge i_clk);
      i_ready = 1'b0;
    end
    check1({tag, "_empty"}, o_valid, 1'b0);
    checki({tag, "_missing"}, sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    i_rst_n    = 1'b0;
    i_rx_sync  = 1'b0;
    i_rx_valid = 1'b1;
    i_rx_data  = 8'h00;
    i_rx_err   = 1'b0;
    i_ready    = 1'b0;
    repeat (3) @(negedge i_clk);
    check_reset_outputs("por");
    i_rst_n = 1'b1;
    #1 check1("por_rst_hold", o_rx_rst, 1'b1);
    @(negedge i_clk);
    check1("por_rst_release", o_rx_rst, 1'b0);
    check1("por_no_byte", o_valid, 1'b0);

    // Single frame
    frame(8'hA5, 1'b1, 1'b0, 1'b0);
    drain("single");

    // Overflow: fifth byte dropped
    for (int i = 1; i <= 4; i++) frame(8'(i), 1'b1, 1'b0, 1'b0);
    frame(8'h05, 1'b0, 1'b0, 1'b0);
    check1("ovf_set", o_ovf, 1'b1);
    drain("ovf");
    check1("ovf_sticky", o_ovf, 1'b1);

    // Reset in the middle of bit 4 with a byte buffered
    frame(8'h77, 1'b1, 1'b0, 1'b0);
    @(negedge i_clk);
    i_rx_sync  = 1'b1;
    i_rx_valid = 1'b0;
    @(negedge i_clk);
    i_rx_sync  = 1'b0;
    repeat (4 * CPB + 2) @(negedge i_clk);
    check1("mid_busy", o_busy, 1'b1);
    i_rst_n    = 1'b0;
    i_rx_valid = 1'b1;
    i_rx_data  = 8'h00;
    sb.delete();
    #1 check_reset_outputs("mid");
    @(negedge i_clk);
    i_rst_n = 1'b1;
    #1 check1("mid_rst_hold", o_rx_rst, 1'b1);
    @(negedge i_clk);
    check1("mid_rst_release", o_rx_rst, 1'b0);
    repeat (3) @(negedge i_clk);
    check1("mid_fifo_empty", o_valid, 1'b0);
    check1("mid_idle", o_busy, 1'b0);

    // Full FIFO with push and pop in the same cycle
    for (int i = 0; i < 4; i++) frame(8'h11 + 8'(i), 1'b1, 1'b0, 1'b0);
    frame(8'h15, 1'b1, 1'b0, 1'b1);
    check1("pushpop_no_ovf", o_ovf, 1'b0);
    drain("pushpop");

    // Bad stop bit, then a clean frame
    frame(8'h00, 1'b0, 1'b1, 1'b0);
    checki("err_cnt_1", int'(o_err_cnt), exp_err_cnt());
    check1("err_no_zero_byte", o_valid, 1'b0);
    frame(8'h3C, 1'b1, 1'b0, 1'b0);
    drain("after_err");

    // Two more errors: three recovery pulses in total
    frame(8'h00, 1'b0, 1'b1, 1'b0);
    frame(8'h00, 1'b0, 1'b1, 1'b0);
    checki("rst_pulses_total", rst_pulses, 3);
    checki("err_cnt_3", int'(o_err_cnt), exp_err_cnt());
    check1("err3_no_byte", o_valid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Sequencing controller for the `uart_rx` receiver.
- Generates the three-per-bit `i_rxpulse` sampling strobes, re-aligned on every `o_rxsync`.
- Detects each newly received byte and buffers it in a small FIFO behind a valid/ready stream.
- Recovers the receiver from its sticky error state by pulsing its reset, and counts errors.
- Sits between `uart_rx` and the byte consumer. The consumer never sees the receiver's raw level-held valid or its sticky error.

## Interface
- `CLKS_PER_BIT`, 48, clock cycles per UART bit. Minimum 4.
- `FIFO_AW`, 2, FIFO address width. Depth is 2^FIFO_AW.
- `i_clk`  in  1  clock; all logic on its rising edge.
- `i_rst_n`  in  1  asynchronous, active-low reset.
- `i_rx_data`  in  8  receiver `o_data`.
- `i_rx_valid`  in  1  receiver `o_valid` (level, held until next start bit).
- `o_rx_ready`  out  1  to receiver `i_ready`; constant 1.
- `i_rx_sync`  in  1  receiver `o_rxsync` (1-cycle start-bit detect).
- `i_rx_err`  in  1  receiver `o_err` (sticky).
- `o_rx_pulse`  out  1  to receiver `i_rxpulse`.
- `o_rx_rst`  out  1  to receiver `i_rst` (active-high).
- `o_data`  out  8  FIFO head byte.
- `o_valid`  out  1  FIFO not empty.
- `i_ready`  in  1  consumer accepts the head byte.
- `o_err_cnt`  out  8  saturating count of receiver errors.
- `o_ovf`  out  1  sticky: a byte was dropped because the FIFO was full.
- `o_busy`  out  1  a frame is in progress (state S_FRAME).

## Operation
- **State machine:**
  - S_IDLE: on `i_rx_sync`=1 → S_FRAME, with bit counter and cycle counter cleared.
  - S_FRAME: cycle counter `c` runs 0..CLKS_PER_BIT-1. At wrap, bit counter `b` increments.
    - Leaving bit 9 (stop bit) at wrap → S_IDLE.
    - `i_rx_sync`=1 while in S_FRAME restarts the frame at b=0, c=0.
  - S_RECOVER: entered from any state on an `i_rx_err` rising edge (`i_rx_err` & ~err_q). It lasts exactly one cycle, then goes to S_IDLE. Error takes priority over sync.
- **Pulses:** let H = CLKS_PER_BIT/2 (floor). In S_FRAME, `o_rx_pulse`=1 when c ∈ {H-1, H, H+1}, giving exactly 30 pulses per full frame. `o_rx_pulse`=0 in every other state.
- **Recovery:** `o_rx_rst`=1 exactly during the S_RECOVER cycle. In that cycle:
  - `o_err_cnt` increments, saturating at 255.
  - The current frame is abandoned.
  - valid_q is forced to 1, so the receiver's post-reset valid=1 with data 0x00 is never captured.
- **Capture:** valid_q is the registered `i_rx_valid`. A push happens when `i_rx_valid` & ~valid_q & not in S_RECOVER; it writes `i_rx_data`.
- **FIFO:** pop on `o_valid` & `i_ready`.
  - Push while full with no pop: byte dropped, `o_ovf` set.
  - Push and pop in the same cycle while full: both performed, nothing dropped.
  - Pop while empty: ignored.
  - Pointers wrap modulo 2^FIFO_AW. A count of FIFO_AW+1 bits distinguishes full from empty.
- **Reset values:** state S_IDLE, `o_rx_pulse` 0, `o_rx_rst` 1, `o_valid` 0, `o_data` 0x00, `o_err_cnt` 0, `o_ovf` 0, `o_busy` 0, valid_q 1, err_q 0, FIFO empty. Reset mid-frame discards the frame and all buffered bytes.

## Timing
- `o_rx_rst` deasserts on the first clock edge after `i_rst_n` rises.
- Cycle counter c=0 on the cycle after `i_rx_sync`. The first pulse occurs H-1 cycles later.
- Byte latency: `o_valid`/`o_data` are updated on the clock edge that samples the `i_rx_valid` rising edge. The byte is therefore visible one cycle after `i_rx_valid` rises.
- Outputs `o_data` and `o_valid` are registered. `o_data` is stable while `o_valid`=1 and `i_ready`=0.
- The `i_rx_err` rising edge is sampled at edge N. `o_rx_rst` is high during cycle N+1 and back to 0 at N+2.

## Configuration
- `UART_RX_CTRL_ERRCNT_EN` defined: the error counter is compiled in as described above.
- Undefined: the counter is omitted and `o_err_cnt` is tied to 0. Recovery (S_RECOVER, `o_rx_rst` pulse, valid_q forcing) is unchanged.

## Test plan
- **Single frame:** CLKS_PER_BIT=16, line frame 0xA5. Required: 30 pulses at c=7,8,9 of bits 0..9; `o_data`=0xA5 with `o_valid` high one cycle after `i_rx_valid` rises; `o_busy` low after bit 9.
- **Overflow:** 5 frames 0x01..0x05 with `i_ready`=0 and FIFO_AW=2. Required: `o_ovf`=1; then pops yield 0x01, 0x02, 0x03, 0x04, and 0x05 is lost.
- **Full FIFO, push and pop together:** `i_ready`=1 in the same cycle as the push. Required: no drop, `o_ovf` stays 0, order preserved.
- **Bad stop bit** (receiver raises `o_err`). Required: `o_rx_rst` high exactly 1 cycle; `o_err_cnt`=1; no 0x00 byte pushed; the next frame 0x3C is received correctly.
- **Reset mid-frame:** assert `i_rst_n` low at bit 4. Required: all outputs at reset values, `o_rx_rst`=1 until the first edge after release, FIFO empty.
- **Macro undefined:** 3 error events. Required: `o_err_cnt` stays 0 and 3 `o_rx_rst` pulses are observed.
